// File: rtl/mlp_engine.sv
// Runtime-configurable MLP inference engine: one time-multiplexed MAC walks every
// neuron of every layer, ping-ponging activations, then streams the final layer out.
module mlp_engine #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int MAX_N  = 4,
    parameter int MAX_L  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int X_BASE = 1 + MAX_L;
    localparam int B_BASE = X_BASE + MAX_N;
    localparam int W_BASE = B_BASE + MAX_L * MAX_N;
    localparam int W_END  = W_BASE + MAX_L * MAX_N * MAX_N;
    localparam int AW     = 2 * WIDTH + 4;
    localparam int LW     = (MAX_L > 1) ? $clog2(MAX_L) : 1;
    localparam int NW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [7:0] MAXN8 = 8'(MAX_N);
    localparam logic [7:0] MAXL8 = 8'(MAX_L);
    localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_WRITE, S_OUT, S_DONE} state_t;
    state_t state, state_n;

    logic [7:0] nl_q, n0_q;
    logic [7:0] nout_q [MAX_L];
    logic       relu_q [MAX_L];
    logic signed [WIDTH-1:0] x_mem [MAX_N];
    logic signed [WIDTH-1:0] b_mem [MAX_L][MAX_N];
    logic signed [WIDTH-1:0] w_mem [MAX_L][MAX_N][MAX_N];
    logic signed [WIDTH-1:0] act   [2][MAX_N];

    logic [LW-1:0] l_cnt;
    logic [NW-1:0] j_cnt, i_cnt, o_cnt;
    logic          wb;
    logic          err_q;
    logic signed [AW-1:0] acc;

    // ---------------- config write decode ----------------
    logic          wr_ok, wr_ctrl, wr_desc, wr_x, wr_b, wr_w;
    logic [LW-1:0] wa_l;
    logic [NW-1:0] wa_j, wa_i;
    int            ai, off;

    always_comb begin
        ai      = int'(cfg_addr);
        off     = 0;
        wr_ok   = cfg_we && !busy;
        wr_ctrl = wr_ok && (ai == 0);
        wr_desc = wr_ok && (ai >= 1) && (ai <= MAX_L);
        wr_x    = wr_ok && (ai >= X_BASE) && (ai < B_BASE);
        wr_b    = wr_ok && (ai >= B_BASE) && (ai < W_BASE);
        wr_w    = wr_ok && (ai >= W_BASE) && (ai < W_END);
        wa_l    = '0;
        wa_j    = '0;
        wa_i    = '0;
        if (wr_desc) wa_l = LW'(ai - 1);
        if (wr_x)    wa_i = NW'(ai - X_BASE);
        if (wr_b) begin
            off  = ai - B_BASE;
            wa_l = LW'(off / MAX_N);
            wa_j = NW'(off % MAX_N);
        end
        if (wr_w) begin
            off  = ai - W_BASE;
            wa_l = LW'(off / (MAX_N * MAX_N));
            wa_j = NW'((off / MAX_N) % MAX_N);
            wa_i = NW'(off % MAX_N);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nl_q <= '0;
            n0_q <= '0;
            for (int l = 0; l < MAX_L; l++) begin
                nout_q[l] <= '0;
                relu_q[l] <= 1'b0;
            end
        end else begin
            if (wr_ctrl) {n0_q, nl_q} <= cfg_data[15:0];
            if (wr_desc) begin
                nout_q[wa_l] <= cfg_data[7:0];
                relu_q[wa_l] <= cfg_data[8];
            end
        end
    end

    // Operand storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_x) x_mem[wa_i] <= cfg_data;
        if (wr_b) b_mem[wa_l][wa_j] <= cfg_data;
        if (wr_w) w_mem[wa_l][wa_j][wa_i] <= cfg_data;
    end

    // Validation sees a same-cycle config write so start uses the new value.
    logic [7:0] nl_n, n0_n, d_n;
    logic       cfg_ok;

    always_comb begin
        nl_n = nl_q;
        n0_n = n0_q;
        d_n  = '0;
        if (wr_ctrl) begin
            nl_n = cfg_data[7:0];
            n0_n = cfg_data[15:8];
        end
        cfg_ok = (nl_n != 8'd0) && (nl_n <= MAXL8) && (n0_n != 8'd0) && (n0_n <= MAXN8);
        for (int l = 0; l < MAX_L; l++) begin
            d_n = nout_q[l];
            if (wr_desc && (int'(wa_l) == l)) d_n = cfg_data[7:0];
            if ((8'(l) < nl_n) && ((d_n == 8'd0) || (d_n > MAXN8))) cfg_ok = 1'b0;
        end
    end

    // ---------------- datapath ----------------
    logic [7:0] cur_nin, cur_nout;
    logic       cur_relu, last_i, last_j, last_l, last_o;
    logic signed [WIDTH-1:0]   x_op, w_op, bias_v, res;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]      sh, acc_init;
    logic [LW-1:0] bl;
    logic [NW-1:0] bj;

    always_comb begin
        cur_nin  = (l_cnt == '0) ? n0_q : nout_q[l_cnt - LW'(1)];
        cur_nout = nout_q[l_cnt];
        cur_relu = relu_q[l_cnt];
        last_i   = (8'(i_cnt) == cur_nin - 8'd1);
        last_j   = (8'(j_cnt) == cur_nout - 8'd1);
        last_l   = (8'(l_cnt) == nl_q - 8'd1);
        last_o   = (8'(o_cnt) == cur_nout - 8'd1);
        x_op     = (l_cnt == '0) ? x_mem[i_cnt] : act[~wb][i_cnt];
        w_op     = w_mem[l_cnt][j_cnt][i_cnt];
        prod     = x_op * w_op;

        sh = acc >>> FRAC;
        if (sh > SMAX)      res = {1'b0, {(WIDTH-1){1'b1}}};
        else if (sh < SMIN) res = {1'b1, {(WIDTH-1){1'b0}}};
        else                res = sh[WIDTH-1:0];
        if (cur_relu && res[WIDTH-1]) res = '0;

        // Bias for the neuron that starts at the coming edge.
        bl = l_cnt;
        bj = j_cnt + NW'(1);
        if (state == S_IDLE) begin
            bl = '0;
            bj = '0;
        end else if (last_j) begin
            bl = l_cnt + LW'(1);
            bj = '0;
        end
        bias_v = b_mem[bl][bj];
        if (wr_b && (wa_l == bl) && (wa_j == bj)) bias_v = cfg_data;
        acc_init = {{(AW-WIDTH-FRAC){bias_v[WIDTH-1]}}, bias_v, {FRAC{1'b0}}};
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start && cfg_ok) state_n = S_MAC;
            S_MAC:   if (last_i) state_n = S_WRITE;
            S_WRITE: state_n = (last_j && last_l) ? S_OUT : S_MAC;
            S_OUT:   if (out_ready && last_o) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_cnt <= '0;
            j_cnt <= '0;
            i_cnt <= '0;
            o_cnt <= '0;
            wb    <= 1'b0;
            acc   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state == S_IDLE) && start && !cfg_ok;
            case (state)
                S_IDLE: if (start && cfg_ok) begin
                    l_cnt <= '0;
                    j_cnt <= '0;
                    i_cnt <= '0;
                    o_cnt <= '0;
                    wb    <= 1'b0;
                    acc   <= acc_init;
                end
                S_MAC: begin
                    acc   <= acc + {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod};
                    i_cnt <= i_cnt + NW'(1);
                end
                S_WRITE: begin
                    act[wb][j_cnt] <= res;
                    i_cnt <= '0;
                    acc   <= acc_init;
                    if (!last_j) begin
                        j_cnt <= j_cnt + NW'(1);
                    end else begin
                        j_cnt <= '0;
                        wb    <= ~wb;
                        if (!last_l) l_cnt <= l_cnt + LW'(1);
                        else         o_cnt <= '0;
                    end
                end
                S_OUT: if (out_ready && !last_o) o_cnt <= o_cnt + NW'(1);
                default: ;
            endcase
        end
    end

    assign busy      = (state == S_MAC) || (state == S_WRITE) || (state == S_OUT);
    assign out_valid = (state == S_OUT);
    assign out_data  = out_valid ? act[~wb][o_cnt] : '0;
    assign done      = (state == S_DONE) || err_q;
    assign err       = err_q;
endmodule

// File: tb/tb_mlp_engine.sv
// Bench for mlp_engine: directed single-layer vectors, legacy 8-layer topology,
// backpressure, error/reset corners and random networks against a behavioural model.
module tb_mlp_engine;
    localparam int X_BASE = 9;
    localparam int B_BASE = 13;
    localparam int W_BASE = 45;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, out_ready;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        busy, done, err, out_valid;
    logic [31:0] out_data;

    mlp_engine dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .busy(busy), .done(done), .err(err),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    int m_x [4];
    int m_b [8][4];
    int m_w [8][4][4];
    int m_nl, m_n0;
    int m_nout [8];
    bit m_relu [8];
    logic [31:0] exp_o [4];
    int exp_T, exp_n;

    typedef struct {
        int          x0, x1, w0, w1, b;
        bit          relu;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = 8'(a); cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic prog_all();
        wr(0, 32'((m_n0 << 8) | m_nl));
        for (int l = 0; l < 8; l++) wr(1 + l, 32'((int'(m_relu[l]) << 8) | m_nout[l]));
        for (int i = 0; i < 4; i++) wr(X_BASE + i, m_x[i]);
        for (int l = 0; l < 8; l++)
            for (int j = 0; j < 4; j++) begin
                wr(B_BASE + l * 4 + j, m_b[l][j]);
                for (int i = 0; i < 4; i++) wr(W_BASE + (l * 4 + j) * 4 + i, m_w[l][j][i]);
            end
    endtask

    // Fixed-point network evaluated with wide integer arithmetic.
    task automatic model_run();
        longint cur [4];
        longint nxt [4];
        longint acc, r;
        int nin;
        for (int i = 0; i < 4; i++) begin cur[i] = longint'(m_x[i]); nxt[i] = 0; end
        nin = m_n0;
        exp_T = 0;
        for (int l = 0; l < m_nl; l++) begin
            for (int j = 0; j < m_nout[l]; j++) begin
                acc = longint'(m_b[l][j]) * 65536;
                for (int i = 0; i < nin; i++) acc += cur[i] * longint'(m_w[l][j][i]);
                r = acc >>> 16;
                if (r > 64'sd2147483647) r = 64'sd2147483647;
                if (r < -64'sd2147483648) r = -64'sd2147483648;
                if (m_relu[l] && r < 0) r = 0;
                nxt[j] = r;
            end
            exp_T += m_nout[l] * (nin + 1);
            for (int j = 0; j < 4; j++) cur[j] = nxt[j];
            nin = m_nout[l];
        end
        exp_n = nin;
        for (int j = 0; j < 4; j++) exp_o[j] = 32'(cur[j]);
    endtask

    task automatic run_check(input string nm, input bit mid_start, input bit we,
                             input int a, input logic [31:0] d);
        int k;
        out_ready = 1'b1;
        start = 1'b1;
        if (we) begin cfg_we = 1'b1; cfg_addr = 8'(a); cfg_data = d; end
        tick();
        start = 1'b0; cfg_we = 1'b0;
        chk({nm, " busy_after_start"}, 32'(busy), 32'd1);
        k = 0;
        while (!out_valid && k < 2000) begin
            if (mid_start && k == 10) start = 1'b1;
            tick();
            start = 1'b0;
            k++;
        end
        chk({nm, " latency"}, k, exp_T);
        for (int w = 0; w < exp_n; w++) begin
            chk($sformatf("%s word%0d", nm, w), out_data, exp_o[w]);
            chk($sformatf("%s valid%0d", nm, w), 32'(out_valid), 32'd1);
            if (w < exp_n - 1) chk($sformatf("%s early_done%0d", nm, w), 32'(done), 32'd0);
            tick();
        end
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " busy_at_done"}, 32'(busy), 32'd0);
        tick();
        chk({nm, " done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic rand_net(input bit legacy);
        bit big;
        big = ($urandom_range(0, 3) == 0);
        if (legacy) begin
            m_nl = 8; m_n0 = 4;
            m_nout = '{4, 2, 1, 1, 1, 2, 4, 4};
            for (int l = 0; l < 8; l++) m_relu[l] = 1'b1;
        end else begin
            m_nl = $urandom_range(1, 8);
            m_n0 = $urandom_range(1, 4);
            for (int l = 0; l < 8; l++) begin
                m_nout[l] = $urandom_range(1, 4);
                m_relu[l] = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 4; i++)
            m_x[i] = legacy ? (int'($urandom_range(0, 5)) << 16)
                            : int'($urandom_range(0, 2097151)) - 1048576;
        for (int l = 0; l < 8; l++)
            for (int j = 0; j < 4; j++) begin
                m_b[l][j] = legacy ? ((int'($urandom_range(0, 5)) - 2) << 16)
                                   : int'($urandom_range(0, 2097151)) - 1048576;
                for (int i = 0; i < 4; i++)
                    m_w[l][j][i] = legacy ? ((int'($urandom_range(0, 4)) - 1) << 16)
                                 : big ? int'($urandom_range(0, 33554431)) - 16777216
                                       : int'($urandom_range(0, 262143)) - 131072;
            end
    endtask

    initial begin
        int cnt;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0; out_ready = 1'b1;
        tbl[0] = '{32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 32'h00004000, 1'b0, 32'hFFFF0000};
        tbl[1] = '{32'h00018000, 32'h00020000, 32'h00008000, 32'hFFFF0000, 32'h00004000, 1'b1, 32'h00000000};
        tbl[2] = '{32'h7FFF0000, 32'h00000000, 32'h00040000, 32'h00000000, 32'h00000000, 1'b0, 32'h7FFFFFFF};
        tbl[3] = '{32'h7FFF0000, 32'h00000000, 32'hFFFC0000, 32'h00000000, 32'h00000000, 1'b0, 32'h80000000};
        tbl[4] = '{32'h7FFF0000, 32'h00000000, 32'hFFFC0000, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000};
        tbl[5] = '{32'h00000001, 32'h00000000, 32'hFFFF8000, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF};
        repeat (3) tick();
        rst = 1'b0;

        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);

        // Unconfigured start must report an error.
        start = 1'b1; tick(); start = 1'b0;
        chk("noconf err", 32'(err), 32'd1);
        chk("noconf done", 32'(done), 32'd1);
        chk("noconf busy", 32'(busy), 32'd0);
        tick();
        chk("noconf err_pulse", 32'(err), 32'd0);
        chk("noconf done_pulse", 32'(done), 32'd0);

        for (int v = 0; v < 6; v++) begin
            wr(0, 32'h0201);
            wr(1, {23'd0, tbl[v].relu, 8'd1});
            wr(X_BASE, tbl[v].x0);
            wr(X_BASE + 1, tbl[v].x1);
            wr(B_BASE, tbl[v].b);
            wr(W_BASE, tbl[v].w0);
            wr(W_BASE + 1, tbl[v].w1);
            exp_T = 3; exp_n = 1; exp_o[0] = tbl[v].exp;
            run_check($sformatf("vec%0d", v), 1'b0, 1'b0, 0, '0);
        end

        // Descriptor written in the start cycle: run must see ReLU on.
        wr(X_BASE, tbl[0].x0); wr(X_BASE + 1, tbl[0].x1);
        wr(B_BASE, tbl[0].b); wr(W_BASE, tbl[0].w0); wr(W_BASE + 1, tbl[0].w1);
        wr(1, 32'h001);
        exp_T = 3; exp_n = 1; exp_o[0] = 32'h0;
        run_check("wr_with_start", 1'b0, 1'b1, 1, 32'h101);

        // n_out out of range.
        wr(0, 32'h0201); wr(1, 32'h005);
        start = 1'b1; tick(); start = 1'b0;
        chk("badn err", 32'(err), 32'd1);
        chk("badn done", 32'(done), 32'd1);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (busy) cnt++;
            if (c > 0 && (err || done)) cnt++;
            tick();
        end
        chk("badn quiet_after", cnt, 0);

        rand_net(1'b1);
        prog_all();
        model_run();
        run_check("legacy", 1'b0, 1'b0, 0, '0);
        run_check("legacy_rerun", 1'b0, 1'b0, 0, '0);
        run_check("legacy_midstart", 1'b1, 1'b0, 0, '0);

        // Backpressure on word 1.
        out_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 2000) begin tick(); cnt++; end
        chk("bp latency", cnt, exp_T);
        chk("bp word0", out_data, exp_o[0]);
        tick();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp hold_data%0d", c), out_data, exp_o[1]);
            chk($sformatf("bp hold_valid%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp hold_done%0d", c), 32'(done), 32'd0);
        end
        out_ready = 1'b1;
        chk("bp word1", out_data, exp_o[1]);
        tick();
        chk("bp word2", out_data, exp_o[2]);
        tick();
        chk("bp word3", out_data, exp_o[3]);
        chk("bp done_early", 32'(done), 32'd0);
        tick();
        chk("bp done", 32'(done), 32'd1);
        tick();

        for (int r = 0; r < 6; r++) begin
            rand_net(1'b0);
            prog_all();
            model_run();
            run_check($sformatf("rand%0d", r), 1'b0, 1'b0, 0, '0);
        end

        // Reset during MAC: back to idle, no done, config cleared.
        rand_net(1'b1);
        prog_all();
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            if (done || out_valid || busy) cnt++;
            tick();
        end
        chk("rst quiet", cnt, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("rst cfg_cleared_err", 32'(err), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mlp_engine.md
# mlp_engine

Parametrised, runtime-configurable multilayer-perceptron inference engine for the GAN datapath. It generalises the team's fixed 8-layer, 4-wide, integer-only generator core. Layer count, per-layer neuron count and per-layer ReLU are programmed through a flat register/memory map. It uses signed fixed-point arithmetic with saturation, a single time-multiplexed MAC, a start/busy/done handshake and a valid/ready output stream.

## Interface
- WIDTH, 32: data/weight/bias width, signed two's complement.
- FRAC, 16: fractional bits (Q(WIDTH-FRAC).FRAC).
- MAX_N, 4: max inputs and neurons per layer.
- MAX_L, 8: max layers.
- ADDR_W, 8: config address width; must cover W_BASE+MAX_L*MAX_N*MAX_N.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  ADDR_W  config word address.
- cfg_data  in  WIDTH  config write data.
- start  in  1  run request, sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of run (also on config error).
- err  out  1  one-cycle pulse with done when config is invalid at start.
- out_data  out  WIDTH  final-layer activation.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.

## Operation
- Address map:
  - 0: CTRL, with [7:0] num_layers (1..MAX_L) and [15:8] n_in0 (1..MAX_N).
  - 1..MAX_L: layer descriptor l-1, with [7:0] n_out (1..MAX_N) and [8] relu_en.
  - X_BASE=1+MAX_L: MAX_N inputs.
  - B_BASE=X_BASE+MAX_N: bias (l,j) at B_BASE+l*MAX_N+j.
  - W_BASE=B_BASE+MAX_L*MAX_N: weight (l,j,i) at W_BASE+(l*MAX_N+j)*MAX_N+i.
- Write rules: writes are accepted only when busy=0. Out-of-map writes are ignored. A write and a start in the same cycle: the write lands first and the run uses the new value.
- Layer sizing: n_in of layer l>0 equals n_out of layer l-1.
- Start validation: in IDLE with start=1, the block checks num_layers, n_in0 and every used n_out against range. If any is invalid, it pulses done and err next cycle and stays IDLE (busy stays 0).
- FSM states: IDLE -> MAC -> WRITE -> (MAC | OUTPUT) -> DONE -> IDLE.
- MAC: one product per cycle, i = 0..n_in-1. The accumulator is 2*WIDTH+4 bits signed, preloaded with bias<<FRAC at neuron start.
- WRITE: result = acc >>> FRAC (arithmetic, floor), saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. If relu_en, negative results become 0. The result is written to the alternate activation bank (ping-pong, MAX_N entries each). After the last neuron the bank is swapped, then the block goes to the next layer or to OUTPUT.
- Activation source: layer 0 reads X; X is never overwritten, so a re-run without rewriting gives an identical result.
- OUTPUT: streams final-layer activations index 0..n_out-1. Index advances on out_valid&&out_ready. out_data/out_valid are held stable while out_ready=0.
- DONE: done pulses for one cycle, busy falls in the same cycle, and the FSM returns to IDLE.
- start while busy=1 is ignored.

## Timing
- Reset values:
  - busy=0, done=0, err=0, out_valid=0, out_data=0, FSM=IDLE.
  - CTRL=0 and descriptors=0, so a start before configuration produces err.
  - X/W/B are not cleared.
- Start latency: start is sampled at edge E; busy=1 after E.
- Compute latency: T = sum over layers of n_out*(n_in+1) cycles. out_valid first goes high after edge E+T.
- Streaming: with out_ready tied 1, one word per cycle, so the last word completes at edge E+T+n_out_last. done is high after that edge, for one cycle.
- Error path: done/err are high after edge E, for one cycle.
- rst mid-run or mid-stream: at the next edge the FSM goes to IDLE, out_valid=0, busy=0, and no done pulse is issued.

## Test plan
- Single layer, FRAC=16: n_in=2, n_out=1; X={0x00018000, 0x00020000}; W={0x00008000, 0xFFFF0000}; B=0x00004000.
  - relu_en=0: out_data=0xFFFF0000.
  - relu_en=1: out_data=0.
  - Both cases: out_valid after edge E+3, done after E+4.
- Saturation: x=0x7FFF0000, w=0x00040000, b=0, relu off -> 0x7FFFFFFF; with w=0xFFFC0000 -> 0x80000000.
- Legacy topology: 8 layers 4->4->2->1->1->1->2->4->4, all ReLU, integer weights programmed ×2^16.
  - Four outputs must match the golden fixed-point model.
  - T=20+10+3+2+2+4+12+20=73.
- Backpressure: hold out_ready=0 for 5 cycles on word 1 -> out_data stable and valid held; order 0..3 preserved; done only after word 3 is accepted.
- Config error: n_out=5 with MAX_N=4, start -> err=done=1 for one cycle, busy never 1. A start while busy is ignored. rst asserted mid-MAC -> IDLE next cycle, with no done pulse.
